// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/response encodings, default-slave
// code, and the default-slave state enum used by the response mux.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [3:0] DEFAULT_SLAVE = 4'd15;
  localparam int         NUM_SLAVES    = 10;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

endpackage

// File: rtl/ahb_resp_mux_if.sv
// Bus bundle between the master side (address phase + returned response)
// and the ten slave response buses feeding the response mux.
interface ahb_resp_mux_if #(
  parameter int DW = 32
);
  logic [1:0]    HTRANS;
  logic [3:0]    MUX_SEL;
  logic          HSEL_NOMAP;

  logic [DW-1:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3, HRDATA_S4;
  logic [DW-1:0] HRDATA_S5, HRDATA_S6, HRDATA_S7, HRDATA_S8, HRDATA_S9;
  logic          HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3, HREADYOUT_S4;
  logic          HREADYOUT_S5, HREADYOUT_S6, HREADYOUT_S7, HREADYOUT_S8, HREADYOUT_S9;
  logic          HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3, HRESP_S4;
  logic          HRESP_S5, HRESP_S6, HRESP_S7, HRESP_S8, HRESP_S9;

  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;
  logic          TIMEOUT_FLAG;

  // Driver side: master address phase plus the slave response buses.
  modport master (
    output HTRANS, MUX_SEL, HSEL_NOMAP,
    output HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3, HRDATA_S4,
    output HRDATA_S5, HRDATA_S6, HRDATA_S7, HRDATA_S8, HRDATA_S9,
    output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3, HREADYOUT_S4,
    output HREADYOUT_S5, HREADYOUT_S6, HREADYOUT_S7, HREADYOUT_S8, HREADYOUT_S9,
    output HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3, HRESP_S4,
    output HRESP_S5, HRESP_S6, HRESP_S7, HRESP_S8, HRESP_S9,
    input  HRDATA, HREADY, HRESP, TIMEOUT_FLAG
  );

  // Mux side: consumes everything above and returns the routed response.
  modport slave (
    input  HTRANS, MUX_SEL, HSEL_NOMAP,
    input  HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3, HRDATA_S4,
    input  HRDATA_S5, HRDATA_S6, HRDATA_S7, HRDATA_S8, HRDATA_S9,
    input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3, HREADYOUT_S4,
    input  HREADYOUT_S5, HREADYOUT_S6, HREADYOUT_S7, HREADYOUT_S8, HREADYOUT_S9,
    input  HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3, HRESP_S4,
    input  HRESP_S5, HRESP_S6, HRESP_S7, HRESP_S8, HRESP_S9,
    output HRDATA, HREADY, HRESP, TIMEOUT_FLAG
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: IDLE/ERR1/ERR2 two-cycle ERROR FSM.
// With AHB_RESP_MUX_TIMEOUT_EN defined it also watches the selected slave
// for excessive stalls and forces a two-cycle ERROR override.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hready,
  input  logic [1:0] htrans,
  input  logic       nomap,
  input  logic       slave_sel,
  input  logic       sel_hreadyout,
  output logic       ds_hready,
  output logic       ds_hresp,
  output logic       ovr_active,
  output logic       ovr_hready,
  output logic       ovr_hresp,
  output logic       timeout_flag
);

  ds_state_e state_q, state_d;
  logic      nomap_xfer;

  // An unmapped active transfer is only taken when the address phase completes.
  assign nomap_xfer = hready && nomap && htrans[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DS_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: ERR1 always completes into ERR2; ERR2 may chain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (nomap_xfer) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = nomap_xfer ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // Output logic: ERR1 stalls with ERROR, ERR2 completes with ERROR.
  always_comb begin
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    case (state_q)
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = HRESP_ERROR;
      end
      DS_ERR2: ds_hresp = HRESP_ERROR;
      default: ;
    endcase
  end

`ifdef AHB_RESP_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr2_q, ovr2_d;
  logic          flag_q, flag_d;
  logic          ovr1;

  // First override cycle starts the moment the stall count hits the limit.
  assign ovr1 = (cnt_q == CW'(TIMEOUT_CYCLES));

  // Stall counter, second-override-cycle marker and sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ovr2_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ovr2_q <= ovr2_d;
      flag_q <= flag_d;
    end
  end

  // Count selected-slave stall cycles; restart on any completed cycle or override.
  always_comb begin
    cnt_d = cnt_q;
    if (hready || ovr1)                 cnt_d = '0;
    else if (slave_sel && !sel_hreadyout) cnt_d = cnt_q + 1'b1;
    ovr2_d = ovr1;
    flag_d = flag_q | ovr1;
  end

  assign ovr_active   = ovr1 | ovr2_q;
  assign ovr_hready   = ovr2_q;
  assign ovr_hresp    = HRESP_ERROR;
  assign timeout_flag = flag_q;
`else
  logic unused_timeout_cfg;

  // Without the watchdog the stall inputs and limit have no consumer.
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES[0], slave_sel, sel_hreadyout};
  assign ovr_active   = 1'b0;
  assign ovr_hready   = 1'b1;
  assign ovr_hresp    = HRESP_OKAY;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite data-phase response mux: routes the registered slave number's
// HRDATA/HREADYOUT/HRESP to the master, or the default slave for codes 10-15.
// Optional stall watchdog enabled by defining AHB_RESP_MUX_TIMEOUT_EN.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  ahb_resp_mux_if.slave  bus
);

  logic [DW-1:0] rdata_s     [NUM_SLAVES];
  logic          hreadyout_s [NUM_SLAVES];
  logic          hresp_s     [NUM_SLAVES];

  assign rdata_s = '{bus.HRDATA_S0, bus.HRDATA_S1, bus.HRDATA_S2, bus.HRDATA_S3,
                     bus.HRDATA_S4, bus.HRDATA_S5, bus.HRDATA_S6, bus.HRDATA_S7,
                     bus.HRDATA_S8, bus.HRDATA_S9};
  assign hreadyout_s = '{bus.HREADYOUT_S0, bus.HREADYOUT_S1, bus.HREADYOUT_S2,
                         bus.HREADYOUT_S3, bus.HREADYOUT_S4, bus.HREADYOUT_S5,
                         bus.HREADYOUT_S6, bus.HREADYOUT_S7, bus.HREADYOUT_S8,
                         bus.HREADYOUT_S9};
  assign hresp_s = '{bus.HRESP_S0, bus.HRESP_S1, bus.HRESP_S2, bus.HRESP_S3,
                     bus.HRESP_S4, bus.HRESP_S5, bus.HRESP_S6, bus.HRESP_S7,
                     bus.HRESP_S8, bus.HRESP_S9};

  logic [3:0]    sel_q, sel_d;
  logic          slave_sel;
  logic [DW-1:0] sel_rdata;
  logic          sel_ready;
  logic          sel_resp;
  logic          ds_hready, ds_hresp;
  logic          ovr_active, ovr_hready, ovr_hresp;
  logic          timeout_flag;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;

  // Data-phase slave number: captured at the end of each completed address phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sel_q <= DEFAULT_SLAVE;
    else          sel_q <= sel_d;
  end

  // Hold the selection across wait states so stall-time MUX_SEL changes are ignored.
  always_comb begin
    sel_d = hready ? bus.MUX_SEL : sel_q;
  end

  // Pick the addressed real slave's response lines (codes 0-9 only).
  always_comb begin
    slave_sel = (sel_q < 4'(NUM_SLAVES));
    sel_rdata = '0;
    sel_ready = 1'b1;
    sel_resp  = HRESP_OKAY;
    if (slave_sel) begin
      sel_rdata = rdata_s[sel_q];
      sel_ready = hreadyout_s[sel_q];
      sel_resp  = hresp_s[sel_q];
    end
  end

  ahb_default_slave #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_default_slave (
    .clk           (HCLK),
    .rst_n         (HRESETn),
    .hready        (hready),
    .htrans        (bus.HTRANS),
    .nomap         (bus.HSEL_NOMAP),
    .slave_sel     (slave_sel),
    .sel_hreadyout (sel_ready),
    .ds_hready     (ds_hready),
    .ds_hresp      (ds_hresp),
    .ovr_active    (ovr_active),
    .ovr_hready    (ovr_hready),
    .ovr_hresp     (ovr_hresp),
    .timeout_flag  (timeout_flag)
  );

  // Final response: watchdog override wins, then a real slave, else the default slave.
  always_comb begin
    hrdata = '0;
    hready = ds_hready;
    hresp  = ds_hresp;
    if (ovr_active) begin
      hready = ovr_hready;
      hresp  = ovr_hresp;
    end else if (slave_sel) begin
      hrdata = sel_rdata;
      hready = sel_ready;
      hresp  = sel_resp;
    end
  end

  assign bus.HRDATA       = hrdata;
  assign bus.HREADY       = hready;
  assign bus.HRESP        = hresp;
  assign bus.TIMEOUT_FLAG = timeout_flag;

endmodule

// File: doc/ahb_resp_mux.md
# ahb_resp_mux

Data-phase response multiplexer and default slave for the AHB-Lite bus. It routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master using the slave number the address decoder produced during the address phase. It also contains the default slave that issues the two-cycle ERROR response for unmapped addresses. It sits between the ten slave response buses and the single master, alongside the address decoder.

## Interface
- DW, 32, data bus width
- TIMEOUT_CYCLES, 64, stall cycles before forced ERROR (timeout build only; must be ≥2)
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- HTRANS  in  2  master transfer type, address phase
- MUX_SEL  in  4  slave number from the address decoder, address phase
- HSEL_NOMAP  in  1  unmapped-address flag from the address decoder
- HRDATA_S0..HRDATA_S9  in  DW each  slave read data
- HREADYOUT_S0..HREADYOUT_S9  in  1 each  slave ready
- HRESP_S0..HRESP_S9  in  1 each  slave response (0 OKAY, 1 ERROR)
- HRDATA  out  DW  read data to master
- HREADY  out  1  bus ready; also fed back to all slaves
- HRESP  out  1  response to master
- TIMEOUT_FLAG  out  1  sticky timeout indicator

## Operation
- sel_q (4 bits) holds the data-phase slave number. It loads MUX_SEL when HREADY=1; otherwise it holds.
- Codes 0–9 route the matching slave: HRDATA, HREADY and HRESP are combinational copies of the selected slave's signals.
- Codes 10–15 route the default slave: HRDATA=0, with HREADY/HRESP from the default-slave FSM.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE: HREADY=1, HRESP=0.
  - IDLE→ERR1 when HREADY=1, HSEL_NOMAP=1 and HTRANS[1]=1 (NONSEQ/SEQ).
  - ERR1: HREADY=0, HRESP=1; always → ERR2.
  - ERR2: HREADY=1, HRESP=1. Goes → ERR1 if a new NOMAP NONSEQ/SEQ is sampled this cycle; otherwise → IDLE.
- NOMAP with HTRANS IDLE/BUSY: zero-wait OKAY; FSM stays in IDLE.
- The FSM only advances on NOMAP transfers. If a valid slave is sampled, the FSM returns to or stays in IDLE.

## Timing
- Reset values: sel_q=15, FSM=IDLE, HREADY=1, HRESP=0, HRDATA=0, TIMEOUT_FLAG=0.
- Latency from slave signals to outputs: zero cycles (combinational). Registered select takes effect one cycle after the address phase.
- Unmapped NONSEQ: exactly 2 data-phase cycles (ERR1, ERR2). The next address is accepted in ERR2.
- Wait states: sel_q is frozen while HREADY=0, so MUX_SEL changes during a stall are ignored.
- Reset mid-transfer: all state returns to reset values asynchronously. The first cycle after release is IDLE/OKAY.

## Configuration
- AHB_RESP_MUX_TIMEOUT_EN, when defined:
  - A stall counter increments each cycle in which sel_q is 0–9 and the selected HREADYOUT=0. It clears whenever HREADY=1.
  - When the counter reaches TIMEOUT_CYCLES, the mux overrides the slave: one cycle HREADY=0/HRESP=1, then one cycle HREADY=1/HRESP=1. The slave's signals are ignored during the override.
  - TIMEOUT_FLAG is set and stays set until reset.
- Without the macro: no counter exists, TIMEOUT_FLAG is tied 0, and slaves may stall indefinitely.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
  - HRESP_OKAY/HRESP_ERROR
  - DEFAULT_SLAVE=4'd15
  - the default-slave state enum
- One sub-module, ahb_default_slave, contains the IDLE/ERR1/ERR2 FSM. It also holds the timeout override logic under the macro.

## Test plan
- Reset, then release HRESETn → HREADY=1, HRESP=0, HRDATA=0, TIMEOUT_FLAG=0.
- NONSEQ with MUX_SEL=2, HRDATA_S2=32'hCAFE_0002, HREADYOUT_S2=1 → the next cycle HRDATA=32'hCAFE_0002, HRESP=0.
- Slave 3 stalls with HREADYOUT_S3=0 for 3 cycles while MUX_SEL toggles to 0 → HREADY=0 for 3 cycles, sel_q stays 3, and data comes from S3 when ready.
- Back-to-back NONSEQ with HSEL_NOMAP=1 → sequence ERR1, ERR2, ERR1, ERR2, with HREADY pattern 0,1,0,1 and HRESP=1 throughout.
- NOMAP with HTRANS=IDLE → HREADY=1, HRESP=0, FSM stays IDLE.
- Timeout build with TIMEOUT_CYCLES=8, HREADYOUT_S1 held 0 → after 8 stall cycles HRESP=1/HREADY=0, then HRESP=1/HREADY=1, and TIMEOUT_FLAG=1 until reset.
